// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry-state encodings for the reorder buffer.
package reorder_buffer_pkg;
  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_RB_SIZE   = 8;
  localparam int DEF_RB_INDEX  = 3;
  localparam int DEF_REG_INDEX = 5;

  typedef enum logic [1:0] {
    RB_FREE    = 2'd0,
    RB_PENDING = 2'd1,
    RB_DONE    = 2'd2
  } rb_state_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB result lanes and commit outputs of the reorder buffer.
interface reorder_buffer_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
);
  logic                         alloc_valid;
  logic                         alloc_is_store;
  logic [REG_INDEX-1:0]         alloc_dest;
  logic                         alloc_ready;
  logic [RB_INDEX-1:0]          alloc_index;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr;
  logic                         we_reg;
  logic [REG_INDEX-1:0]         ws_reg;
  logic [WORD_SIZE-1:0]         wd_reg;
  logic [RB_INDEX-1:0]          commit_tag;
  logic                         mem_we;
  logic [WORD_SIZE-1:0]         mem_addr;
  logic [WORD_SIZE-1:0]         mem_data;
  logic                         empty;

  modport master (
    output alloc_valid, alloc_is_store, alloc_dest,
    output CDB_data_data, CDB_data_valid, CDB_data_addr,
    input  alloc_ready, alloc_index, empty,
    input  we_reg, ws_reg, wd_reg, commit_tag, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  alloc_valid, alloc_is_store, alloc_dest,
    input  CDB_data_data, CDB_data_valid, CDB_data_addr,
    output alloc_ready, alloc_index, empty,
    output we_reg, ws_reg, wd_reg, commit_tag, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/reorder_buffer_rb_entry.sv
// One reorder-buffer slot: FREE -> PENDING on allocate, -> DONE on CDB capture, -> FREE on retire.
// State updates one edge after the strobe; valid on a non-PENDING slot is dropped.
module rb_entry
  import reorder_buffer_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int REG_INDEX = DEF_REG_INDEX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_alloc,
  input  logic                 i_is_store,
  input  logic [REG_INDEX-1:0] i_dest,
  input  logic                 i_cdb_vld,
  input  logic [WORD_SIZE-1:0] i_cdb_data,
  input  logic [WORD_SIZE-1:0] i_cdb_addr,
  input  logic                 i_retire,
  output rb_state_t            o_state,
  output logic                 o_is_store,
  output logic [REG_INDEX-1:0] o_dest,
  output logic [WORD_SIZE-1:0] o_data,
  output logic [WORD_SIZE-1:0] o_addr
);
  rb_state_t            r_state;
  logic                 r_is_store;
  logic [REG_INDEX-1:0] r_dest;
  logic [WORD_SIZE-1:0] r_data;
  logic [WORD_SIZE-1:0] r_addr;

  // Allocate, capture and retire are mutually exclusive per slot by construction of head/tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RB_FREE;
      r_is_store <= 1'b0;
      r_dest     <= '0;
      r_data     <= '0;
      r_addr     <= '0;
    end else if (i_alloc) begin
      r_state    <= RB_PENDING;
      r_is_store <= i_is_store;
      r_dest     <= i_dest;
    end else if (i_cdb_vld && r_state == RB_PENDING) begin
      r_state <= RB_DONE;
      r_data  <= i_cdb_data;
      r_addr  <= i_cdb_addr;
    end else if (i_retire) begin
      r_state <= RB_FREE;
    end
  end

  assign o_state    = r_state;
  assign o_is_store = r_is_store;
  assign o_dest     = r_dest;
  assign o_data     = r_data;
  assign o_addr     = r_addr;
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit stage: allocates slots at issue, captures CDB lanes, retires one DONE head per cycle.
// Grant is combinational from count (full refuses even while committing); commit strobes are registered.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int RB_SIZE   = DEF_RB_SIZE,
  parameter int RB_INDEX  = DEF_RB_INDEX,
  parameter int REG_INDEX = DEF_REG_INDEX
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave bus
);
  localparam logic [RB_INDEX:0] CNT_FULL = (RB_INDEX+1)'(RB_SIZE);

  logic [RB_INDEX-1:0]  r_head, r_tail;
  logic [RB_INDEX:0]    r_count;
  logic                 r_we_reg, r_mem_we;
  logic [REG_INDEX-1:0] r_ws_reg;
  logic [WORD_SIZE-1:0] r_wd_reg, r_mem_addr, r_mem_data;
  logic [RB_INDEX-1:0]  r_commit_tag;

  rb_state_t            w_state    [RB_SIZE];
  logic                 w_is_store [RB_SIZE];
  logic [REG_INDEX-1:0] w_dest     [RB_SIZE];
  logic [WORD_SIZE-1:0] w_data     [RB_SIZE];
  logic [WORD_SIZE-1:0] w_addr     [RB_SIZE];

  logic w_alloc_ready, w_alloc_fire, w_commit;

  assign w_alloc_ready = (r_count != CNT_FULL);
  assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
  assign w_commit      = (w_state[r_head] == RB_DONE);

  for (genvar g = 0; g < RB_SIZE; g++) begin : g_entry
    rb_entry #(.WORD_SIZE(WORD_SIZE), .REG_INDEX(REG_INDEX)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .i_alloc   (w_alloc_fire && r_tail == RB_INDEX'(g)),
      .i_is_store(bus.alloc_is_store),
      .i_dest    (bus.alloc_dest),
      .i_cdb_vld (bus.CDB_data_valid[g]),
      .i_cdb_data(bus.CDB_data_data[g*WORD_SIZE +: WORD_SIZE]),
      .i_cdb_addr(bus.CDB_data_addr[g*WORD_SIZE +: WORD_SIZE]),
      .i_retire  (w_commit && r_head == RB_INDEX'(g)),
      .o_state   (w_state[g]),
      .o_is_store(w_is_store[g]),
      .o_dest    (w_dest[g]),
      .o_data    (w_data[g]),
      .o_addr    (w_addr[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_we_reg     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_ws_reg     <= '0;
      r_wd_reg     <= '0;
      r_commit_tag <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      if (w_alloc_fire) r_tail <= r_tail + RB_INDEX'(1);
      if (w_commit)     r_head <= r_head + RB_INDEX'(1);
      case ({w_alloc_fire, w_commit})
        2'b10:   r_count <= r_count + (RB_INDEX+1)'(1);
        2'b01:   r_count <= r_count - (RB_INDEX+1)'(1);
        default: r_count <= r_count;
      endcase
      r_we_reg <= w_commit && !w_is_store[r_head];
      r_mem_we <= w_commit && w_is_store[r_head];
      // Data outputs hold their last committed value between strobes.
      if (w_commit) begin
        r_commit_tag <= r_head;
        if (w_is_store[r_head]) begin
          r_mem_addr <= w_addr[r_head];
          r_mem_data <= w_data[r_head];
        end else begin
          r_ws_reg <= w_dest[r_head];
          r_wd_reg <= w_data[r_head];
        end
      end
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.alloc_index = r_tail;
  assign bus.empty       = (r_count == '0);
  assign bus.we_reg      = r_we_reg;
  assign bus.ws_reg      = r_ws_reg;
  assign bus.wd_reg      = r_wd_reg;
  assign bus.commit_tag  = r_commit_tag;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data    = r_mem_data;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: per-cycle vector table plus hand sequences for fill/wrap and reset.
module tb_reorder_buffer;
  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst;
    bit          av;
    bit          ast;
    logic [4:0]  adst;
    bit          cv;
    int          lane;
    logic [31:0] cd;
    logic [31:0] ca;
    bit          e_rdy;
    logic [2:0]  e_idx;
    bit          e_emp;
    bit          e_we;
    logic [4:0]  e_ws;
    logic [31:0] e_wd;
    logic [2:0]  e_tag;
    bit          e_mwe;
    logic [31:0] e_ma;
    logic [31:0] e_md;
  } vec_t;

  function automatic vec_t mk(bit rst, bit av, bit ast, logic [4:0] adst,
                              bit cv, int lane, logic [31:0] cd, logic [31:0] ca,
                              bit e_rdy, logic [2:0] e_idx, bit e_emp,
                              bit e_we, logic [4:0] e_ws, logic [31:0] e_wd, logic [2:0] e_tag,
                              bit e_mwe, logic [31:0] e_ma, logic [31:0] e_md);
    vec_t v;
    v.rst = rst; v.av = av; v.ast = ast; v.adst = adst;
    v.cv = cv; v.lane = lane; v.cd = cd; v.ca = ca;
    v.e_rdy = e_rdy; v.e_idx = e_idx; v.e_emp = e_emp;
    v.e_we = e_we; v.e_ws = e_ws; v.e_wd = e_wd; v.e_tag = e_tag;
    v.e_mwe = e_mwe; v.e_ma = e_ma; v.e_md = e_md;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_valid    = 1'b0;
    bus.alloc_is_store = 1'b0;
    bus.alloc_dest     = '0;
    bus.CDB_data_valid = '0;
    bus.CDB_data_data  = '0;
    bus.CDB_data_addr  = '0;
  endtask

  task automatic do_alloc(input logic [4:0] dest);
    @(negedge clk);
    idle_inputs();
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = dest;
  endtask

  vec_t vecs[20];

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Row semantics: inputs for this cycle, expected outputs seen before the next edge.
    vecs[0]  = mk(0,1,0,1,  0,0,0,0,         1,0,1, 0,0,0,0,        0,0,0);
    vecs[1]  = mk(0,1,0,2,  0,0,0,0,         1,1,0, 0,0,0,0,        0,0,0);
    vecs[2]  = mk(0,1,0,3,  0,0,0,0,         1,2,0, 0,0,0,0,        0,0,0);
    vecs[3]  = mk(0,0,0,0,  1,2,32'h22,0,    1,3,0, 0,0,0,0,        0,0,0);
    vecs[4]  = mk(0,0,0,0,  1,0,32'h11,0,    1,3,0, 0,0,0,0,        0,0,0);
    vecs[5]  = mk(0,0,0,0,  1,1,32'h33,0,    1,3,0, 0,0,0,0,        0,0,0);
    vecs[6]  = mk(0,0,0,0,  0,0,0,0,         1,3,0, 1,1,32'h11,0,   0,0,0);
    vecs[7]  = mk(0,0,0,0,  0,0,0,0,         1,3,0, 1,2,32'h33,1,   0,0,0);
    vecs[8]  = mk(0,0,0,0,  0,0,0,0,         1,3,1, 1,3,32'h22,2,   0,0,0);
    vecs[9]  = mk(1,0,0,0,  0,0,0,0,         1,3,1, 0,0,0,0,        0,0,0);
    vecs[10] = mk(0,1,1,0,  0,0,0,0,         1,0,1, 0,0,0,0,        0,0,0);
    vecs[11] = mk(0,0,0,0,  1,0,32'hAB,32'h40, 1,1,0, 0,0,0,0,      0,0,0);
    vecs[12] = mk(0,0,0,0,  0,0,0,0,         1,1,0, 0,0,0,0,        0,0,0);
    vecs[13] = mk(0,0,0,0,  0,0,0,0,         1,1,1, 0,0,0,0,        1,32'h40,32'hAB);
    vecs[14] = mk(0,0,0,0,  1,1,32'h55,32'h66, 1,1,1, 0,0,0,0,      0,0,0);
    vecs[15] = mk(0,1,0,7,  0,0,0,0,         1,1,1, 0,0,0,0,        0,0,0);
    vecs[16] = mk(0,0,0,0,  1,1,32'h77,0,    1,2,0, 0,0,0,0,        0,0,0);
    vecs[17] = mk(0,0,0,0,  1,1,32'h99,0,    1,2,0, 0,0,0,0,        0,0,0);
    vecs[18] = mk(0,0,0,0,  0,0,0,0,         1,2,1, 1,7,32'h77,1,   0,0,0);
    vecs[19] = mk(0,0,0,0,  0,0,0,0,         1,2,1, 0,0,0,0,        0,0,0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_we_reg", 32'(bus.we_reg), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_ws_reg", 32'(bus.ws_reg), 0);
    chk("rst_wd_reg", bus.wd_reg, 0);
    chk("rst_commit_tag", 32'(bus.commit_tag), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_alloc_index", 32'(bus.alloc_index), 0);
    chk("rst_empty", 32'(bus.empty), 1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_inputs();
      reset              = vecs[i].rst;
      bus.alloc_valid    = vecs[i].av;
      bus.alloc_is_store = vecs[i].ast;
      bus.alloc_dest     = vecs[i].adst;
      if (vecs[i].cv) begin
        bus.CDB_data_valid[vecs[i].lane]         = 1'b1;
        bus.CDB_data_data[vecs[i].lane*32 +: 32] = vecs[i].cd;
        bus.CDB_data_addr[vecs[i].lane*32 +: 32] = vecs[i].ca;
      end
      #1;
      chk($sformatf("v%0d_alloc_ready", i), 32'(bus.alloc_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_alloc_index", i), 32'(bus.alloc_index), 32'(vecs[i].e_idx));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e_emp));
      chk($sformatf("v%0d_we_reg", i), 32'(bus.we_reg), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_mwe));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_ws_reg", i), 32'(bus.ws_reg), 32'(vecs[i].e_ws));
        chk($sformatf("v%0d_wd_reg", i), bus.wd_reg, vecs[i].e_wd);
      end
      if (vecs[i].e_mwe) begin
        chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_ma);
        chk($sformatf("v%0d_mem_data", i), bus.mem_data, vecs[i].e_md);
      end
      if (vecs[i].e_we || vecs[i].e_mwe)
        chk($sformatf("v%0d_commit_tag", i), 32'(bus.commit_tag), 32'(vecs[i].e_tag));
    end

    // Fill, refuse while full (even with a commit pending), then wrap.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_alloc(5'(8 + i));
      #1;
      chk($sformatf("fill%0d_index", i), 32'(bus.alloc_index), 32'(i));
      chk($sformatf("fill%0d_ready", i), 32'(bus.alloc_ready), 1);
    end
    do_alloc(5'd30);
    #1;
    chk("full_ready", 32'(bus.alloc_ready), 0);
    chk("full_index", 32'(bus.alloc_index), 0);
    chk("full_empty", 32'(bus.empty), 0);
    @(negedge clk);
    bus.CDB_data_valid[0]     = 1'b1;
    bus.CDB_data_data[31:0]   = 32'h100;
    #1;
    chk("full_ready_capture", 32'(bus.alloc_ready), 0);
    @(negedge clk);
    bus.CDB_data_valid = '0;
    #1;
    chk("full_ready_head_done", 32'(bus.alloc_ready), 0);
    chk("full_no_strobe_yet", 32'(bus.we_reg), 0);
    do_alloc(5'd20);
    #1;
    chk("wrap_we_reg", 32'(bus.we_reg), 1);
    chk("wrap_ws_reg", 32'(bus.ws_reg), 8);
    chk("wrap_wd_reg", bus.wd_reg, 32'h100);
    chk("wrap_tag", 32'(bus.commit_tag), 0);
    chk("wrap_ready", 32'(bus.alloc_ready), 1);
    chk("wrap_index", 32'(bus.alloc_index), 0);
    @(negedge clk);
    idle_inputs();
    bus.CDB_data_valid = '1;
    for (int i = 0; i < 8; i++) bus.CDB_data_data[i*32 +: 32] = 32'h200 + 32'(i);
    #1;
    chk("refill_ready", 32'(bus.alloc_ready), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("b2b_pre_we", 32'(bus.we_reg), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("b2b%0d_we", k), 32'(bus.we_reg), 1);
      chk($sformatf("b2b%0d_tag", k), 32'(bus.commit_tag), 32'((k + 1) % 8));
      chk($sformatf("b2b%0d_ws", k), 32'(bus.ws_reg), (k < 7) ? 32'(9 + k) : 32'd20);
      chk($sformatf("b2b%0d_wd", k), bus.wd_reg, 32'h200 + 32'((k + 1) % 8));
    end
    @(negedge clk);
    #1;
    chk("b2b_done_we", 32'(bus.we_reg), 0);
    chk("b2b_done_empty", 32'(bus.empty), 1);

    // Reset with entries in flight discards them.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) do_alloc(5'(1 + i));
    @(negedge clk);
    idle_inputs();
    bus.CDB_data_valid = 8'b0000_0110;
    bus.CDB_data_data[32 +: 32] = 32'hEE;
    bus.CDB_data_data[64 +: 32] = 32'hEF;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("inflight_empty", 32'(bus.empty), 0);
    chk("inflight_we", 32'(bus.we_reg), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_we", 32'(bus.we_reg), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.CDB_data_valid[1] = 1'b1;
    #1;
    chk("rstmid_after_we", 32'(bus.we_reg), 0);
    chk("rstmid_after_mem_we", 32'(bus.mem_we), 0);
    chk("rstmid_after_empty", 32'(bus.empty), 1);
    chk("rstmid_after_index", 32'(bus.alloc_index), 0);
    chk("rstmid_after_ready", 32'(bus.alloc_ready), 1);
    do_alloc(5'd9);
    @(negedge clk);
    idle_inputs();
    bus.CDB_data_valid[0]   = 1'b1;
    bus.CDB_data_data[31:0] = 32'h5A;
    #1;
    chk("post_rst_we_idle", 32'(bus.we_reg), 0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("post_rst_we", 32'(bus.we_reg), 1);
    chk("post_rst_ws", 32'(bus.ws_reg), 9);
    chk("post_rst_wd", bus.wd_reg, 32'h5A);
    chk("post_rst_tag", 32'(bus.commit_tag), 0);
    @(negedge clk);
    #1;
    chk("post_rst_no_stale", 32'(bus.we_reg), 0);
    chk("post_rst_empty", 32'(bus.empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
